// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU op codes, phase encodings, register-file reset values.
package cpu_pkg;

  localparam int unsigned REG_AW   = 2;
  localparam int unsigned RF_DEPTH = 4;
  localparam int unsigned RST_W    = 8;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    PH_FETCH   = 2'd0,
    PH_DECODE  = 2'd1,
    PH_EXECUTE = 2'd2,
    PH_WRITE   = 2'd3
  } phase_e;

  localparam logic [RST_W-1:0] RF_RST_R0 = 8'h05;
  localparam logic [RST_W-1:0] RF_RST_R1 = 8'h03;
  localparam logic [RST_W-1:0] RF_RST_R2 = 8'h0A;
  localparam logic [RST_W-1:0] RF_RST_R3 = 8'h0F;

  // Reset value of register-file entry idx.
  function automatic logic [RST_W-1:0] rf_reset_val(input logic [REG_AW-1:0] idx);
    case (idx)
      2'd0:    rf_reset_val = RF_RST_R0;
      2'd1:    rf_reset_val = RF_RST_R1;
      2'd2:    rf_reset_val = RF_RST_R2;
      default: rf_reset_val = RF_RST_R3;
    endcase
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: add/sub with carry-borrow, bitwise and/or, zero flag.
import cpu_pkg::*;

module alu_core #(
  parameter int unsigned DATA_W = 8
) (
  input  alu_op_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0] sum_ext;
  logic [DATA_W:0] diff_ext;

  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};

  // Operation select; the borrow is the extended difference's top bit (a < b).
  always_comb begin
    y     = '0;
    carry = 1'b0;
    case (op)
      ALU_ADD: begin
        y     = sum_ext[DATA_W-1:0];
        carry = sum_ext[DATA_W];
      end
      ALU_SUB: begin
        y     = diff_ext[DATA_W-1:0];
        carry = diff_ext[DATA_W];
      end
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/datapath_unit.sv
// Multicycle execution datapath: register file, operand/result registers, phase tracking.
// Optional build macro DATAPATH_SYNC_CHECK_EN enables the sync_err pulse and phase resync.
import cpu_pkg::*;

module datapath_unit #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        alu_op,
  input  logic [1:0]        read_reg1,
  input  logic [1:0]        read_reg2,
  input  logic [1:0]        write_reg,
  input  logic              reg_write,
  input  logic [1:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              carry,
  output logic              wb_valid,
  output logic [1:0]        wb_addr,
  output logic              sync_err
);

  phase_e            phase_q, phase_d;
  logic [DATA_W-1:0] rf_q [RF_DEPTH];
  logic [DATA_W-1:0] rf_d [RF_DEPTH];
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  alu_op_e           op_q, op_d;
  logic [1:0]        wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d;
  logic              carry_q, carry_d;
  logic              sync_err_q, sync_err_d;

  logic [DATA_W-1:0] alu_y;
  logic              alu_carry;
  logic              alu_zero;

  alu_core #(.DATA_W(DATA_W)) u_alu (
    .op    (op_q),
    .a     (op_a_q),
    .b     (op_b_q),
    .y     (alu_y),
    .carry (alu_carry),
    .zero  (alu_zero)
  );

  assign wb_valid = (phase_q == PH_WRITE) && reg_write;

  // Next-state for phase counter, pipeline registers and register file.
  always_comb begin
    phase_d    = phase_e'(phase_q + 2'd1);
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_d       = op_q;
    wb_addr_d  = wb_addr_q;
    result_d   = result_q;
    zero_d     = zero_q;
    carry_d    = carry_q;
    sync_err_d = 1'b0;
    rf_d       = rf_q;

    case (phase_q)
      PH_DECODE: begin
        op_a_d    = rf_q[read_reg1];
        op_b_d    = rf_q[read_reg2];
        op_d      = alu_op_e'(alu_op);
        wb_addr_d = write_reg;
      end
      PH_EXECUTE: begin
        result_d = alu_y;
        zero_d   = alu_zero;
        carry_d  = alu_carry;
      end
      PH_WRITE: begin
        if (reg_write) rf_d[wb_addr_q] = result_q;
      end
      default: ;
    endcase

`ifdef DATAPATH_SYNC_CHECK_EN
    // A strobe outside WRITE means the control unit is ahead; restart at FETCH.
    sync_err_d = (reg_write != (phase_q == PH_WRITE));
    if (reg_write && (phase_q != PH_WRITE)) phase_d = PH_FETCH;
`endif
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q    <= PH_FETCH;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_q       <= ALU_ADD;
      wb_addr_q  <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      sync_err_q <= 1'b0;
      for (int i = 0; i < RF_DEPTH; i++) begin
        rf_q[i] <= DATA_W'(rf_reset_val(REG_AW'(i)));
      end
    end else begin
      phase_q    <= phase_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_q       <= op_d;
      wb_addr_q  <= wb_addr_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      sync_err_q <= sync_err_d;
      rf_q       <= rf_d;
    end
  end

  assign dbg_data = rf_q[dbg_addr];
  assign result   = result_q;
  assign zero     = zero_q;
  assign carry    = carry_q;
  assign wb_addr  = wb_addr_q;
  assign sync_err = sync_err_q;

endmodule

// File: doc/datapath_unit.md
# datapath_unit

Execution datapath driven by the multicycle control unit. Consumes `alu_op`, `read_reg1`, `read_reg2`, `write_reg` and `reg_write`. Holds the 4-entry register file, the operand/result registers and the ALU. Tracks the same 4-phase FETCH/DECODE/EXECUTE/WRITE cycle internally, so it knows when the zero-defaulted control fields are valid.

## Interface
- `DATA_W`, default 8: register/ALU width.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `alu_op`  in  2  operation code; valid only in the DECODE phase.
- `write_reg`  in  2  destination index; valid only in DECODE.
- `read_reg1`  in  2  source A index; valid only in DECODE.
- `read_reg2`  in  2  source B index; valid only in DECODE.
- `reg_write`  in  1  write strobe; high for exactly the WRITE phase.
- `dbg_addr`  in  2  debug read index.
- `dbg_data`  out  DATA_W  combinational `rf[dbg_addr]`.
- `result`  out  DATA_W  registered ALU result.
- `zero`  out  1  registered, `result == 0`.
- `carry`  out  1  registered carry/borrow.
- `wb_valid`  out  1  high in the cycle a register-file write occurs.
- `wb_addr`  out  2  latched destination index.
- `sync_err`  out  1  one-cycle phase mismatch pulse.

## Operation
- Phase counter, 2 bits:
  - Encoding: FETCH=0, DECODE=1, EXECUTE=2, WRITE=3.
  - Resets to FETCH and advances by 1 each cycle, wrapping WRITE→FETCH, in lockstep with the control unit.
- FETCH: no state changes.
- DECODE, at clock edge, latch:
  - `op_a <= rf[read_reg1]`
  - `op_b <= rf[read_reg2]`
  - `op_q <= alu_op`
  - `wb_addr <= write_reg`
- EXECUTE, at clock edge, latch the ALU output into `result`, `zero` and `carry`. ALU operations:
  - ADD (00): `{carry, result} = op_a + op_b`, wraps modulo 2^DATA_W.
  - SUB (01): `result = op_a - op_b` modulo 2^DATA_W; `carry = (op_a < op_b)` (borrow).
  - AND (10): `carry = 0`.
  - OR (11): `carry = 0`.
- WRITE: when `reg_write` is high, `rf[wb_addr] <= result` at the edge, and `wb_valid` is high this cycle.
- Sources equal to the destination, e.g. SUB R1,R2,R1, are safe: operands are captured in DECODE, before writeback.
- Register-file reset values: R0=0x05, R1=0x03, R2=0x0A, R3=0x0F.
- Other reset values: `op_a`, `op_b`, `op_q`, `wb_addr`, `result`, `zero`, `carry`, `sync_err` all 0.

## Timing
- After `reset` deassertion, cycle k is phase k mod 4.
- DECODE operands are captured at the end of cycle 1.
- `result` is visible from cycle 3 (WRITE).
- The register-file update is visible on `dbg_data` from the following FETCH.
- Instruction latency: 4 cycles; throughput: 1 instruction per 4 cycles.
- `wb_valid = (phase == WRITE) & reg_write`, combinational.
- `reg_write` high in a non-WRITE phase: no write, `wb_valid` 0.
- `reg_write` low in WRITE: no write; the phase still wraps to FETCH.
- Reset mid-instruction:
  - Phase goes immediately to FETCH and all registers return to reset values.
  - An in-flight result is discarded.

## Configuration
- `DATAPATH_SYNC_CHECK_EN` defined:
  - `sync_err` is registered and pulses for one cycle after any cycle where `reg_write != (phase == WRITE)`.
  - If `reg_write` was seen high outside WRITE, the phase is forced to FETCH on the next cycle (resynchronisation).
- Not defined: `sync_err` is tied 0, there is no resync, and the phase counter free-runs.

## Structure
- Shared package `cpu_pkg` holds:
  - ALU op encodings (ALU_ADD/SUB/AND/OR).
  - Phase encodings (PH_FETCH..PH_WRITE).
  - Register-file reset constants.
- The control unit uses the same package.
- One combinational sub-module, `alu_core`:
  - Inputs: `op`, `a`, `b`.
  - Outputs: `y`, `carry`, `zero`.
- Register file, phase counter and pipeline registers stay in `datapath_unit`.

## Test plan
- Reset, then drive the 4-instruction program (ADD R0,R1,R3; SUB R1,R2,R1; AND R0,R0,R2; OR R3,R3,R0) with correct phasing. Required:
  - `wb_valid` in cycles 3, 7, 11, 15.
  - `result` = 0x12, 0x07, 0x02, 0x0F.
  - Final R0=0x02, R1=0x07, R2=0x0A, R3=0x0F.
- Force R0=0xFF and R1=0x01 (via prior ops), then ADD R2,R0,R1 → `result` 0x00, `zero`=1, `carry`=1.
- SUB with a=0x03, b=0x0A → `result` 0xF9, `carry`=1, `zero`=0.
- Assert `reg_write` in DECODE (sync check on):
  - No register write.
  - `sync_err` high for one cycle.
  - Phase is FETCH on the cycle after the strobe.
- Assert `reset` during EXECUTE:
  - All outputs 0.
  - Register file back to 05/03/0A/0F.
  - `dbg_data` for R0 reads 0x05 while reset is held.
- Hold `reg_write` low in WRITE → `wb_valid` 0, register file unchanged, `sync_err` pulses (when enabled).
